stage_mem: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM latch outputs, performs loads and stores over a request/acknowledge data bus, and stalls the pipeline while an access is outstanding. It handles big-endian byte-lane alignment, sign and zero extension, misalignment detection, and optionally LL/SC link tracking. Its register, HI and LO write fields feed the MEM/WB latch.

---
 rtl/stage_mem_pkg.sv | 29 ++
 rtl/mem_align.sv | 106 ++++++++++
 rtl/stage_mem.sv | 253 +++++++++++++++++++++++++
 tb/tb_stage_mem.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage.
// Holds operator codes, write/stall/reset polarity constants and the
// FSM state encoding used by stage_mem and mem_align.
package stage_mem_pkg;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic [7:0] OPERATOR_LB  = 8'h20;
    localparam logic [7:0] OPERATOR_LH  = 8'h21;
    localparam logic [7:0] OPERATOR_LW  = 8'h23;
    localparam logic [7:0] OPERATOR_LBU = 8'h24;
    localparam logic [7:0] OPERATOR_LHU = 8'h25;
    localparam logic [7:0] OPERATOR_SB  = 8'h28;
    localparam logic [7:0] OPERATOR_SH  = 8'h29;
    localparam logic [7:0] OPERATOR_SW  = 8'h2b;
    localparam logic [7:0] OPERATOR_LL  = 8'h30;
    localparam logic [7:0] OPERATOR_SC  = 8'h38;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_WAIT = 2'd1,
        MEM_STATE_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational big-endian alignment unit for the memory stage.
// Decodes the operator, flags misaligned accesses, produces the byte-lane
// select and lane-replicated store data, and extracts/extends load data.
// Ports:
//   operator    in  8   operation code
//   offset      in  2   address bits [1:0]
//   store_data  in  32  rt value for stores
//   read_data   in  32  word returned by the bus
//   is_memory   out 1   operator is a load or store
//   is_store    out 1   operator writes memory
//   misaligned  out 1   address not aligned to access size
//   select      out 4   byte lanes, bit 3 = bits [31:24]
//   write_data  out 32  replicated store data
//   load_data   out 32  aligned, sign/zero-extended load result
module mem_align
    import stage_mem_pkg::*;
(
    input  logic [7:0]  operator,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic        is_memory,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  select,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [3:0]  byte_select;

    always_comb begin
        lane_byte   = read_data[31:24];
        byte_select = 4'b1000;
        case (offset)
            2'd1: begin lane_byte = read_data[23:16]; byte_select = 4'b0100; end
            2'd2: begin lane_byte = read_data[15:8];  byte_select = 4'b0010; end
            2'd3: begin lane_byte = read_data[7:0];   byte_select = 4'b0001; end
            default: ;
        endcase
        lane_half = offset[1] ? read_data[15:0] : read_data[31:16];
    end

    always_comb begin
        is_memory  = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        select     = 4'b0000;
        write_data = 32'h0;
        load_data  = 32'h0;
        case (operator)
            OPERATOR_LB: begin
                is_memory = 1'b1;
                select    = byte_select;
                load_data = {{24{lane_byte[7]}}, lane_byte};
            end
            OPERATOR_LBU: begin
                is_memory = 1'b1;
                select    = byte_select;
                load_data = {24'h0, lane_byte};
            end
            OPERATOR_LH: begin
                is_memory  = 1'b1;
                misaligned = offset[0];
                select     = offset[1] ? 4'b0011 : 4'b1100;
                load_data  = {{16{lane_half[15]}}, lane_half};
            end
            OPERATOR_LHU: begin
                is_memory  = 1'b1;
                misaligned = offset[0];
                select     = offset[1] ? 4'b0011 : 4'b1100;
                load_data  = {16'h0, lane_half};
            end
            OPERATOR_LW, OPERATOR_LL: begin
                is_memory  = 1'b1;
                misaligned = |offset;
                select     = 4'b1111;
                load_data  = read_data;
            end
            OPERATOR_SB: begin
                is_memory  = 1'b1;
                is_store   = 1'b1;
                select     = byte_select;
                write_data = {4{store_data[7:0]}};
            end
            OPERATOR_SH: begin
                is_memory  = 1'b1;
                is_store   = 1'b1;
                misaligned = offset[0];
                select     = offset[1] ? 4'b0011 : 4'b1100;
                write_data = {2{store_data[15:0]}};
            end
            OPERATOR_SW, OPERATOR_SC: begin
                is_memory  = 1'b1;
                is_store   = 1'b1;
                misaligned = |offset;
                select     = 4'b1111;
                write_data = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage of the five-stage MIPS pipeline.
// Non-memory ops pass through to the MEM/WB fields combinationally. Loads and
// stores run over a request/acknowledge bus while stall_request holds the
// pipeline; the result is presented from a register once the ack arrives.
// Optional feature macro: MEM_LLSC_EN enables LL/SC link-bit tracking.
// Ports:
//   clock, reset (synchronous, active-high)
//   stall[5:0] (bit 4 = MEM/WB held), llbit_clear
//   mem_* : EX/MEM latch fields (operator, address, store data, GPR/HI/LO)
//   bus_ack, bus_read_data : slave response
//   bus_request, bus_write, bus_address, bus_select, bus_write_data : master
//   stall_request, address_error
//   wb_* : GPR/HI/LO write fields to the MEM/WB latch
//
// state | meaning
// IDLE  | pass-through; a legal memory op issues its request this cycle
// WAIT  | request held on the bus, pipeline stalled until bus_ack
// DONE  | registered result presented; held while stall[4] is set
module stage_mem
    import stage_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        llbit_clear,
    input  logic [31:0] mem_instruction,
    input  logic [7:0]  mem_operator,
    input  logic [31:0] mem_operand_a,
    input  logic [31:0] mem_operand_b,
    input  logic        mem_register_write_enable,
    input  logic [4:0]  mem_register_write_address,
    input  logic [31:0] mem_register_write_data,
    input  logic        mem_register_hi_write_enable,
    input  logic [31:0] mem_register_hi_write_data,
    input  logic        mem_register_lo_write_enable,
    input  logic [31:0] mem_register_lo_write_data,
    input  logic        bus_ack,
    input  logic [31:0] bus_read_data,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_select,
    output logic [31:0] bus_write_data,
    output logic        stall_request,
    output logic        address_error,
    output logic        wb_register_write_enable,
    output logic [4:0]  wb_register_write_address,
    output logic [31:0] wb_register_write_data,
    output logic        wb_register_hi_write_enable,
    output logic [31:0] wb_register_hi_write_data,
    output logic        wb_register_lo_write_enable,
    output logic [31:0] wb_register_lo_write_data
);

    mem_state_t  state;

    logic [7:0]  held_operator;
    logic [1:0]  held_offset;
    logic        held_write;
    logic [31:0] held_address;
    logic [3:0]  held_select;
    logic [31:0] held_write_data;
    logic        held_reg_we;
    logic [4:0]  held_reg_address;
    logic [31:0] held_reg_data;
    logic        held_hi_we;
    logic [31:0] held_hi_data;
    logic        held_lo_we;
    logic [31:0] held_lo_data;

    logic        is_memory;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  align_select;
    logic [31:0] align_write_data;
    logic [31:0] align_load_data;
    logic [7:0]  align_operator;
    logic [1:0]  align_offset;
    logic        sc_fail;
    logic        start;

    // Outside IDLE the aligner works from the captured op so the load result
    // does not depend on the EX/MEM latch staying put.
    assign align_operator = (state == MEM_STATE_IDLE) ? mem_operator : held_operator;
    assign align_offset   = (state == MEM_STATE_IDLE) ? mem_operand_a[1:0] : held_offset;

    mem_align u_align (
        .operator   (align_operator),
        .offset     (align_offset),
        .store_data (mem_operand_b),
        .read_data  (bus_read_data),
        .is_memory  (is_memory),
        .is_store   (is_store),
        .misaligned (misaligned),
        .select     (align_select),
        .write_data (align_write_data),
        .load_data  (align_load_data)
    );

`ifdef MEM_LLSC_EN
    logic llbit;

    // A concurrent clear beats setting the link on LL completion.
    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            llbit <= 1'b0;
        end else if (llbit_clear) begin
            llbit <= 1'b0;
        end else if (state == MEM_STATE_WAIT && bus_ack) begin
            if (held_write)
                llbit <= 1'b0;
            else if (held_operator == OPERATOR_LL)
                llbit <= 1'b1;
        end
    end

    assign sc_fail = (mem_operator == OPERATOR_SC) && (llbit == 1'b0);

    logic unused_inputs;
    assign unused_inputs = ^{mem_instruction, stall[5], stall[3:0]};
`else
    assign sc_fail = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{mem_instruction, stall[5], stall[3:0], llbit_clear};
`endif

    assign start = is_memory && !misaligned && !sc_fail;

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            state            <= MEM_STATE_IDLE;
            held_operator    <= 8'h0;
            held_offset      <= 2'b00;
            held_write       <= 1'b0;
            held_address     <= 32'h0;
            held_select      <= 4'b0000;
            held_write_data  <= 32'h0;
            held_reg_we      <= WRITE_DISABLE;
            held_reg_address <= 5'd0;
            held_reg_data    <= 32'h0;
            held_hi_we       <= WRITE_DISABLE;
            held_hi_data     <= 32'h0;
            held_lo_we       <= WRITE_DISABLE;
            held_lo_data     <= 32'h0;
        end else begin
            case (state)
                MEM_STATE_IDLE: begin
                    if (start) begin
                        held_operator    <= mem_operator;
                        held_offset      <= mem_operand_a[1:0];
                        held_write       <= is_store;
                        held_address     <= {mem_operand_a[31:2], 2'b00};
                        held_select      <= align_select;
                        held_write_data  <= align_write_data;
                        // SC reports success through rt; plain stores never write a GPR.
                        if (mem_operator == OPERATOR_SC) begin
                            held_reg_we   <= WRITE_ENABLE;
                            held_reg_data <= 32'd1;
                        end else begin
                            held_reg_we   <= is_store ? WRITE_DISABLE : mem_register_write_enable;
                            held_reg_data <= mem_register_write_data;
                        end
                        held_reg_address <= mem_register_write_address;
                        held_hi_we       <= mem_register_hi_write_enable;
                        held_hi_data     <= mem_register_hi_write_data;
                        held_lo_we       <= mem_register_lo_write_enable;
                        held_lo_data     <= mem_register_lo_write_data;
                        state            <= MEM_STATE_WAIT;
                    end
                end
                MEM_STATE_WAIT: begin
                    if (bus_ack) begin
                        if (!held_write)
                            held_reg_data <= align_load_data;
                        state <= MEM_STATE_DONE;
                    end
                end
                MEM_STATE_DONE: begin
                    if (!stall[4])
                        state <= MEM_STATE_IDLE;
                end
                default: state <= MEM_STATE_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_request                 = 1'b0;
        bus_write                   = 1'b0;
        bus_address                 = 32'h0;
        bus_select                  = 4'b0000;
        bus_write_data              = 32'h0;
        stall_request               = STALL_DISABLE;
        address_error               = 1'b0;
        wb_register_write_enable    = WRITE_DISABLE;
        wb_register_write_address   = 5'd0;
        wb_register_write_data      = 32'h0;
        wb_register_hi_write_enable = WRITE_DISABLE;
        wb_register_hi_write_data   = 32'h0;
        wb_register_lo_write_enable = WRITE_DISABLE;
        wb_register_lo_write_data   = 32'h0;
        if (reset != RESET_ENABLE) begin
            case (state)
                MEM_STATE_IDLE: begin
                    wb_register_write_enable    = mem_register_write_enable;
                    wb_register_write_address   = mem_register_write_address;
                    wb_register_write_data      = mem_register_write_data;
                    wb_register_hi_write_enable = mem_register_hi_write_enable;
                    wb_register_hi_write_data   = mem_register_hi_write_data;
                    wb_register_lo_write_enable = mem_register_lo_write_enable;
                    wb_register_lo_write_data   = mem_register_lo_write_data;
                    if (is_memory) begin
                        if (misaligned) begin
                            address_error            = 1'b1;
                            wb_register_write_enable = WRITE_DISABLE;
                        end else if (sc_fail) begin
                            wb_register_write_enable = WRITE_ENABLE;
                            wb_register_write_data   = 32'h0;
                        end else begin
                            bus_request              = 1'b1;
                            bus_write                = is_store;
                            bus_address              = {mem_operand_a[31:2], 2'b00};
                            bus_select               = align_select;
                            bus_write_data           = align_write_data;
                            stall_request            = STALL_ENABLE;
                            wb_register_write_enable = WRITE_DISABLE;
                        end
                    end
                end
                MEM_STATE_WAIT: begin
                    bus_request    = 1'b1;
                    bus_write      = held_write;
                    bus_address    = held_address;
                    bus_select     = held_select;
                    bus_write_data = held_write_data;
                    stall_request  = STALL_ENABLE;
                end
                MEM_STATE_DONE: begin
                    wb_register_write_enable    = held_reg_we;
                    wb_register_write_address   = held_reg_address;
                    wb_register_write_data      = held_reg_data;
                    wb_register_hi_write_enable = held_hi_we;
                    wb_register_hi_write_data   = held_hi_data;
                    wb_register_lo_write_enable = held_lo_we;
                    wb_register_lo_write_data   = held_lo_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Testbench for stage_mem: directed scenarios followed by random memory and
// non-memory operations, checked against a behavioural byte-lane model.
module tb_stage_mem;
    import stage_mem_pkg::*;

    localparam logic [7:0] OP_NOP = 8'h00;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        llbit_clear;
    logic [31:0] mem_instruction;
    logic [7:0]  mem_operator;
    logic [31:0] mem_operand_a;
    logic [31:0] mem_operand_b;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic        mem_register_hi_write_enable;
    logic [31:0] mem_register_hi_write_data;
    logic        mem_register_lo_write_enable;
    logic [31:0] mem_register_lo_write_data;
    logic        bus_ack;
    logic [31:0] bus_read_data;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [3:0]  bus_select;
    logic [31:0] bus_write_data;
    logic        stall_request;
    logic        address_error;
    logic        wb_register_write_enable;
    logic [4:0]  wb_register_write_address;
    logic [31:0] wb_register_write_data;
    logic        wb_register_hi_write_enable;
    logic [31:0] wb_register_hi_write_data;
    logic        wb_register_lo_write_enable;
    logic [31:0] wb_register_lo_write_data;

    int total = 0;
    int bad   = 0;
    logic llb = 1'b0;

    stage_mem dut (
        .clock                        (clock),
        .reset                        (reset),
        .stall                        (stall),
        .llbit_clear                  (llbit_clear),
        .mem_instruction              (mem_instruction),
        .mem_operator                 (mem_operator),
        .mem_operand_a                (mem_operand_a),
        .mem_operand_b                (mem_operand_b),
        .mem_register_write_enable    (mem_register_write_enable),
        .mem_register_write_address   (mem_register_write_address),
        .mem_register_write_data      (mem_register_write_data),
        .mem_register_hi_write_enable (mem_register_hi_write_enable),
        .mem_register_hi_write_data   (mem_register_hi_write_data),
        .mem_register_lo_write_enable (mem_register_lo_write_enable),
        .mem_register_lo_write_data   (mem_register_lo_write_data),
        .bus_ack                      (bus_ack),
        .bus_read_data                (bus_read_data),
        .bus_request                  (bus_request),
        .bus_write                    (bus_write),
        .bus_address                  (bus_address),
        .bus_select                   (bus_select),
        .bus_write_data               (bus_write_data),
        .stall_request                (stall_request),
        .address_error                (address_error),
        .wb_register_write_enable     (wb_register_write_enable),
        .wb_register_write_address    (wb_register_write_address),
        .wb_register_write_data       (wb_register_write_data),
        .wb_register_hi_write_enable  (wb_register_hi_write_enable),
        .wb_register_hi_write_data    (wb_register_hi_write_data),
        .wb_register_lo_write_enable  (wb_register_lo_write_enable),
        .wb_register_lo_write_data    (wb_register_lo_write_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from access size and byte offset (big-endian).
    function automatic void model(
        input  logic [7:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [31:0] rd,
        input  logic        in_we,
        input  logic [31:0] in_wd,
        input  logic        link,
        output logic        is_mem,
        output logic        err,
        output logic        access,
        output logic        wr,
        output logic [3:0]  sel,
        output logic [31:0] wdata,
        output logic        we,
        output logic [31:0] wval
    );
        int size;
        int off;
        bit sgn;
        longint v;
        is_mem = 1'b1;
        wr     = 1'b0;
        sgn    = 1'b0;
        size   = 4;
        case (op)
            OPERATOR_LB:              begin size = 1; sgn = 1'b1; end
            OPERATOR_LBU:             size = 1;
            OPERATOR_LH:              begin size = 2; sgn = 1'b1; end
            OPERATOR_LHU:             size = 2;
            OPERATOR_LW, OPERATOR_LL: size = 4;
            OPERATOR_SB:              begin size = 1; wr = 1'b1; end
            OPERATOR_SH:              begin size = 2; wr = 1'b1; end
            OPERATOR_SW, OPERATOR_SC: begin size = 4; wr = 1'b1; end
            default:                  is_mem = 1'b0;
        endcase
        off    = int'(a[1:0]);
        err    = is_mem && ((off % size) != 0);
        sel    = 4'b0000;
        v      = 0;
        if (!err) begin
            sel = 4'(((1 << size) - 1) << (4 - size - off));
            v   = (longint'(rd) >> (8 * (4 - size - off))) & ((longint'(1) << (8 * size)) - 1);
            if (sgn && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
        end
        if (size == 1)      wdata = b[7:0] * 32'h01010101;
        else if (size == 2) wdata = b[15:0] * 32'h00010001;
        else                wdata = b;
        access = is_mem && !err;
        we     = in_we;
        wval   = in_wd;
        if (is_mem) begin
            if (err) begin
                we = 1'b0;
            end else if (op == OPERATOR_SC) begin
`ifdef MEM_LLSC_EN
                if (!link) access = 1'b0;
`endif
                we   = 1'b1;
                wval = access ? 32'd1 : 32'd0;
            end else if (wr) begin
                we = 1'b0;
            end else begin
                wval = 32'(v);
            end
        end
    endfunction

    task automatic drive_nop();
        mem_operator              = OP_NOP;
        mem_register_write_enable = 1'b0;
        bus_ack                   = 1'b0;
    endtask

    // One instruction through the stage; ack after k cycles, DONE held for hold cycles.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rd, input int k, input int hold);
        logic is_mem, err, access, wr, we;
        logic [3:0]  sel;
        logic [31:0] wdata, wval, hi_d, lo_d;
        logic [4:0]  waddr;
        logic        hi_we, lo_we;
        hi_d  = $urandom;
        lo_d  = $urandom;
        waddr = 5'($urandom_range(0, 31));
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        mem_instruction              = $urandom;
        mem_operator                 = op;
        mem_operand_a                = a;
        mem_operand_b                = b;
        mem_register_write_enable    = 1'($urandom_range(0, 1));
        mem_register_write_address   = waddr;
        mem_register_write_data      = $urandom;
        mem_register_hi_write_enable = hi_we;
        mem_register_hi_write_data   = hi_d;
        mem_register_lo_write_enable = lo_we;
        mem_register_lo_write_data   = lo_d;
        bus_ack                      = 1'b0;
        stall                        = 6'b0;
        model(op, a, b, rd, mem_register_write_enable, mem_register_write_data, llb,
              is_mem, err, access, wr, sel, wdata, we, wval);
        #1;
        if (!access) begin
            check("imm_address_error", 32'(address_error), 32'(err));
            check("imm_bus_request", 32'(bus_request), 32'd0);
            check("imm_stall_request", 32'(stall_request), 32'd0);
            check("imm_wb_we", 32'(wb_register_write_enable), 32'(we));
            if (we) check("imm_wb_data", wb_register_write_data, wval);
            if (!is_mem) begin
                check("pass_hi_data", wb_register_hi_write_data, hi_d);
                check("pass_lo_we", 32'(wb_register_lo_write_enable), 32'(lo_we));
            end
            tick();
            drive_nop();
            #1;
            check("after_address_error", 32'(address_error), 32'd0);
            return;
        end
        check("req_bus_request", 32'(bus_request), 32'd1);
        check("req_bus_write", 32'(bus_write), 32'(wr));
        check("req_bus_address", bus_address, a & 32'hFFFF_FFFC);
        check("req_bus_select", 32'(bus_select), 32'(sel));
        if (wr) check("req_bus_write_data", bus_write_data, wdata);
        check("req_stall_request", 32'(stall_request), 32'd1);
        check("req_address_error", 32'(address_error), 32'd0);
        for (int i = 1; i <= k; i++) begin
            tick();
            if (i == k) begin
                bus_ack       = 1'b1;
                bus_read_data = rd;
            end else begin
                bus_read_data = $urandom;
            end
            #1;
            check("wait_stall_request", 32'(stall_request), 32'd1);
            check("wait_bus_request", 32'(bus_request), 32'd1);
            check("wait_bus_select", 32'(bus_select), 32'(sel));
            check("wait_bus_address", bus_address, a & 32'hFFFF_FFFC);
        end
        tick();
        bus_ack       = 1'b0;
        bus_read_data = $urandom;
        stall[4]      = (hold > 0);
        #1;
        check("done_stall_request", 32'(stall_request), 32'd0);
        check("done_bus_request", 32'(bus_request), 32'd0);
        check("done_wb_we", 32'(wb_register_write_enable), 32'(we));
        if (we) check("done_wb_data", wb_register_write_data, wval);
        check("done_wb_address", 32'(wb_register_write_address), 32'(waddr));
        check("done_hi_data", wb_register_hi_write_data, hi_d);
        check("done_lo_we", 32'(wb_register_lo_write_enable), 32'(lo_we));
        for (int h = 0; h < hold; h++) begin
            bus_ack       = (h == 0);
            bus_read_data = $urandom;
            tick();
            bus_ack  = 1'b0;
            stall[4] = (h < hold - 1);
            #1;
            check("hold_stall_request", 32'(stall_request), 32'd0);
            check("hold_wb_we", 32'(wb_register_write_enable), 32'(we));
            if (we) check("hold_wb_data", wb_register_write_data, wval);
        end
        tick();
        drive_nop();
        stall = 6'b0;
        if (wr) llb = 1'b0;
        else if (op == OPERATOR_LL) llb = 1'b1;
        #1;
        check("back_idle_stall_request", 32'(stall_request), 32'd0);
    endtask

    logic [7:0] ops_list [11] = '{OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU,
                                  OPERATOR_LW, OPERATOR_SB, OPERATOR_SH, OPERATOR_SW,
                                  OPERATOR_LL, OPERATOR_SC, OP_NOP};

    initial begin
        logic [31:0] ra;
        reset                        = 1'b1;
        stall                        = 6'b0;
        llbit_clear                  = 1'b0;
        mem_instruction              = 32'h0;
        mem_operator                 = OPERATOR_LW;
        mem_operand_a                = 32'h100;
        mem_operand_b                = 32'h0;
        mem_register_write_enable    = 1'b1;
        mem_register_write_address   = 5'd3;
        mem_register_write_data      = 32'h55;
        mem_register_hi_write_enable = 1'b1;
        mem_register_hi_write_data   = 32'h77;
        mem_register_lo_write_enable = 1'b1;
        mem_register_lo_write_data   = 32'h99;
        bus_ack                      = 1'b0;
        bus_read_data                = 32'h0;
        tick();
        tick();
        check("reset_bus_request", 32'(bus_request), 32'd0);
        check("reset_stall_request", 32'(stall_request), 32'd0);
        check("reset_wb_we", 32'(wb_register_write_enable), 32'd0);
        check("reset_wb_hi_data", wb_register_hi_write_data, 32'd0);
        check("reset_bus_select", 32'(bus_select), 32'd0);
        drive_nop();
        reset = 1'b0;
        tick();

        run_mem(OPERATOR_LW,  32'h100, 32'h0, 32'h11223344, 2, 0);
        run_mem(OPERATOR_LB,  32'h103, 32'h0, 32'h000000F0, 1, 0);
        run_mem(OPERATOR_LBU, 32'h103, 32'h0, 32'h000000F0, 1, 0);
        run_mem(OPERATOR_SH,  32'h202, 32'hABCD1234, 32'h0, 1, 0);
        run_mem(OPERATOR_LW,  32'h101, 32'h0, 32'h0, 1, 0);
        run_mem(OPERATOR_LH,  32'h402, 32'h0, 32'h1234_8765, 3, 3);
        run_mem(OPERATOR_LL,  32'h40, 32'h0, 32'hCAFEF00D, 1, 0);
        run_mem(OPERATOR_SC,  32'h40, 32'h13572468, 32'h0, 2, 0);
        run_mem(OPERATOR_LL,  32'h40, 32'h0, 32'h0BADBEEF, 1, 0);
        llbit_clear = 1'b1;
        tick();
        llbit_clear = 1'b0;
        llb = 1'b0;
        run_mem(OPERATOR_SC,  32'h40, 32'h2468ACE0, 32'h0, 1, 1);

        // Reset in WAIT abandons the access; a late ack is ignored.
        mem_operator              = OPERATOR_LW;
        mem_operand_a             = 32'h300;
        mem_register_write_enable = 1'b1;
        #1;
        check("rst_wait_req", 32'(bus_request), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rst_wait_bus_request", 32'(bus_request), 32'd0);
        tick();
        drive_nop();
        reset = 1'b0;
        #1;
        check("rst_after_bus_request", 32'(bus_request), 32'd0);
        check("rst_after_stall", 32'(stall_request), 32'd0);
        bus_ack       = 1'b1;
        bus_read_data = 32'hDEAD0001;
        tick();
        bus_ack = 1'b0;
        #1;
        check("late_ack_wb_we", 32'(wb_register_write_enable), 32'd0);
        check("late_ack_stall", 32'(stall_request), 32'd0);
        check("late_ack_bus_request", 32'(bus_request), 32'd0);
        llb = 1'b0;
        run_mem(OPERATOR_LHU, 32'h306, 32'h0, 32'hFFFF_8001, 1, 0);

        for (int t = 0; t < 80; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_mem(ops_list[$urandom_range(0, 10)], ra, $urandom, $urandom,
                    $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
